// File: rtl/bram_arb_pkg.sv
// Shared definitions for the load-BRAM arbiter: port ids, tracker entry, read latency.
package bram_arb_pkg;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // One in-flight read slot: occupied flag plus the requester that issued it.
    typedef struct packed {
        logic valid;
        logic port;
    } trk_entry_t;

    // BRAM read latency in cycles from the enable cycle to DO valid.
    function automatic int unsigned bram_latency(input int unsigned pipelined);
        return (pipelined != 0) ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/bram_rsp_tracker.sv
// Fixed-depth shift register of in-flight read tags; the last stage lines up with BRAM_DO.
module bram_rsp_tracker
    import bram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  trk_entry_t push_i,
    output trk_entry_t tap_o,
    output logic       any_valid_o
);

    trk_entry_t [DEPTH-1:0] sr_q;
    trk_entry_t [DEPTH-1:0] sr_d;

    // Shift one stage per cycle, new entry enters at index 0.
    always_comb begin
        sr_d = {sr_q[DEPTH-2:0], push_i};
    end

    // Tracker storage; reset drops every in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Tap and any-valid summary.
    always_comb begin
        tap_o       = sr_q[DEPTH-1];
        any_valid_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid_o = any_valid_o | sr_q[i].valid;
        end
    end

endmodule

// File: rtl/bram1_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported load BRAM.
// Port 0 is fetch, port 1 is load/store. Define BRAM_ARB_ROUND_ROBIN_EN for
// round-robin on contention; otherwise port 0 always wins.
module bram1_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic                  r0_req_we,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_wdata,
    output logic                  r0_resp_valid,
    output logic [DATA_WIDTH-1:0] r0_resp_data,

    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic                  r1_req_we,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_wdata,
    output logic                  r1_resp_valid,
    output logic [DATA_WIDTH-1:0] r1_resp_data,

    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO,

    output logic                  busy
);

    localparam int unsigned LAT       = bram_latency(PIPELINED);
    localparam int unsigned TRK_DEPTH = LAT + 1;

    logic                  gnt0;
    logic                  gnt1;
    logic                  accept;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  en_q;
    logic                  en_d;
    logic                  we_q;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] di_q;
    logic [DATA_WIDTH-1:0] di_d;

    trk_entry_t            trk_push;
    trk_entry_t            trk_tap;
    logic                  trk_any;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic prio_q;
    logic prio_d;
    logic contended;

    // Round-robin grant: on contention the port named by prio wins.
    always_comb begin
        contended = r0_req_valid & r1_req_valid & ~RST;
        gnt0      = r0_req_valid & ~RST & ~(contended & prio_q);
        gnt1      = r1_req_valid & ~RST & ~gnt0;
        prio_d    = prio_q;
        if (contended) begin
            prio_d = gnt0;
        end
    end

    // Priority pointer, only moved by contended grants.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority: fetch port always wins.
    always_comb begin
        gnt0 = r0_req_valid & ~RST;
        gnt1 = r1_req_valid & ~RST & ~r0_req_valid;
    end
`endif

    // Select the granted command and build the next BRAM drive and tracker tag.
    always_comb begin
        accept    = gnt0 | gnt1;
        cmd_we    = gnt1 ? r1_req_we    : r0_req_we;
        cmd_addr  = gnt1 ? r1_req_addr  : r0_req_addr;
        cmd_wdata = gnt1 ? r1_req_wdata : r0_req_wdata;

        en_d   = accept;
        we_d   = accept & cmd_we;
        addr_d = addr_q;
        di_d   = di_q;
        if (accept) begin
            addr_d = cmd_addr;
            di_d   = cmd_wdata;
        end

        trk_push.valid = accept & ~cmd_we;
        trk_push.port  = gnt1 ? PORT_LSU : PORT_FETCH;
    end

    // Registered BRAM port drive; address and data hold through idle cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            di_q   <= '0;
        end else begin
            en_q   <= en_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            di_q   <= di_d;
        end
    end

    bram_rsp_tracker #(
        .DEPTH (TRK_DEPTH)
    ) u_trk (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (trk_push),
        .tap_o       (trk_tap),
        .any_valid_o (trk_any)
    );

    // Output mapping; read data is shared, only the valid pulse is steered.
    always_comb begin
        r0_req_ready  = gnt0;
        r1_req_ready  = gnt1;
        BRAM_EN       = en_q;
        BRAM_WE       = we_q;
        BRAM_ADDR     = addr_q;
        BRAM_DI       = di_q;
        r0_resp_valid = trk_tap.valid & (trk_tap.port == PORT_FETCH);
        r1_resp_valid = trk_tap.valid & (trk_tap.port == PORT_LSU);
        r0_resp_data  = BRAM_DO;
        r1_resp_data  = BRAM_DO;
        busy          = trk_any;
    end

endmodule

// File: tb/tb_bram1_arbiter.sv
// Scoreboard bench: two arbiters (PIPELINED=0 and 1) see identical stimulus,
// each backed by its own behavioural BRAM.
module tb_bram1_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       r0v = 1'b0, r0we = 1'b0, r1v = 1'b0, r1we = 1'b0;
    logic [7:0] r0a = '0, r0d = '0, r1a = '0, r1d = '0;

    logic       a_rdy0, a_rdy1, a_rv0, a_rv1, a_en, a_we, a_busy;
    logic [7:0] a_rd0, a_rd1, a_addr, a_di, a_do;
    logic       b_rdy0, b_rdy1, b_rv0, b_rv1, b_en, b_we, b_busy;
    logic [7:0] b_rd0, b_rd1, b_addr, b_di, b_do, b_raw;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram1_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .PIPELINED(0)) ua (
        .CLK(clk), .RST(rst),
        .r0_req_valid(r0v), .r0_req_ready(a_rdy0), .r0_req_we(r0we), .r0_req_addr(r0a),
        .r0_req_wdata(r0d), .r0_resp_valid(a_rv0), .r0_resp_data(a_rd0),
        .r1_req_valid(r1v), .r1_req_ready(a_rdy1), .r1_req_we(r1we), .r1_req_addr(r1a),
        .r1_req_wdata(r1d), .r1_resp_valid(a_rv1), .r1_resp_data(a_rd1),
        .BRAM_EN(a_en), .BRAM_WE(a_we), .BRAM_ADDR(a_addr), .BRAM_DI(a_di),
        .BRAM_DO(a_do), .busy(a_busy)
    );

    bram1_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .PIPELINED(1)) ub (
        .CLK(clk), .RST(rst),
        .r0_req_valid(r0v), .r0_req_ready(b_rdy0), .r0_req_we(r0we), .r0_req_addr(r0a),
        .r0_req_wdata(r0d), .r0_resp_valid(b_rv0), .r0_resp_data(b_rd0),
        .r1_req_valid(r1v), .r1_req_ready(b_rdy1), .r1_req_we(r1we), .r1_req_addr(r1a),
        .r1_req_wdata(r1d), .r1_resp_valid(b_rv1), .r1_resp_data(b_rd1),
        .BRAM_EN(b_en), .BRAM_WE(b_we), .BRAM_ADDR(b_addr), .BRAM_DI(b_di),
        .BRAM_DO(b_do), .busy(b_busy)
    );

    // Behavioural BRAMs: latency 1 (A) and latency 2 with output register (B).
    always @(posedge clk) begin
        if (a_en) begin
            if (a_we) mem_a[a_addr] <= a_di;
            else      a_do <= mem_a[a_addr];
        end
        if (b_en) begin
            if (b_we) mem_b[b_addr] <= b_di;
            else      b_raw <= mem_b[b_addr];
        end
        b_do <= b_raw;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor for one DUT: pops the scoreboard on each resp pulse.
    task automatic mon(input bit is_b, input logic v0, input logic v1, input logic [7:0] d);
        exp_t  e;
        string tag;
        int    sz;
        tag = is_b ? "B" : "A";
        sz  = is_b ? qb.size() : qa.size();
        if (v0 || v1) begin
            if (v0 && v1) chk({tag, "_resp_onehot"}, 32'({v0, v1}), 32'(2'b01));
            if (sz == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_resp: got port=%0d data=%0h expected none (cycle %0d)",
                         tag, v1, d, cyc);
            end else begin
                e = is_b ? qb.pop_front() : qa.pop_front();
                chk({tag, "_resp_port"}, 32'(v1), 32'(e.port));
                chk({tag, "_resp_data"}, 32'(d), 32'(e.data));
                chk({tag, "_resp_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end else if (sz != 0) begin
            e = is_b ? qb[0] : qa[0];
            if (e.cyc <= cyc) begin
                checks++;
                failures++;
                $display("FAIL %s_missing_resp: got none expected port=%0d data=%0h at cycle %0d",
                         tag, e.port, e.data, e.cyc);
                if (is_b) void'(qb.pop_front());
                else      void'(qa.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, a_rv0, a_rv1, a_rv1 ? a_rd1 : a_rd0);
        mon(1'b1, b_rv0, b_rv1, b_rv1 ? b_rd1 : b_rd0);
    end

    // Drive one cycle of requests, check ready, and post expected read responses.
    task automatic step(input logic v0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic v1, input logic we1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic e0, input logic e1, input logic [7:0] edat);
        @(negedge clk);
        r0v = v0; r0we = we0; r0a = a0; r0d = d0;
        r1v = v1; r1we = we1; r1a = a1; r1d = d1;
        #1;
        chk("A_ready", 32'({a_rdy0, a_rdy1}), 32'({e0, e1}));
        chk("B_ready", 32'({b_rdy0, b_rdy1}), 32'({e0, e1}));
        if ((e0 && !we0) || (e1 && !we1)) begin
            qa.push_back('{port: e1, data: edat, cyc: cyc + 2});
            qb.push_back('{port: e1, data: edat, cyc: cyc + 3});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            r0v = 1'b0; r1v = 1'b0; r0we = 1'b0; r1we = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        // Reset state, with both requesters asking.
        r0v = 1'b1; r1v = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", 32'({a_rdy0, a_rdy1, b_rdy0, b_rdy1}), 32'(4'b0000));
        chk("rst_en_we", 32'({a_en, a_we, b_en, b_we}), 32'(4'b0000));
        chk("rst_addr_di", 32'({a_addr, a_di}), 32'(16'h0000));
        chk("rst_busy", 32'({a_busy, b_busy}), 32'(2'b00));
        r0v = 1'b0; r1v = 1'b0;
        rst = 1'b0;
        idle(1);

        // Preload through port 1 writes; writes produce no response.
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd5, 8'hA5, 0, 1, 8'h00);
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd1, 8'h11, 0, 1, 8'h00);
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd2, 8'h22, 0, 1, 8'h00);
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd3, 8'h33, 0, 1, 8'h00);
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd4, 8'h44, 0, 1, 8'h00);
        idle(3);

        // Single read from fetch port; BRAM driven the following cycle.
        step(1, 0, 8'd5, 8'h00, 0, 0, 8'd0, 8'h00, 1, 0, 8'hA5);
        @(posedge clk);
        #1;
        chk("rd_bram_cmd", 32'({a_en, a_we, a_addr}), 32'({1'b1, 1'b0, 8'd5}));
        idle(4);

        // Four contended cycles.
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        step(1, 0, 8'd1, 8'h00, 1, 0, 8'd2, 8'h00, 1, 0, 8'h11);
        step(1, 0, 8'd3, 8'h00, 1, 0, 8'd2, 8'h00, 0, 1, 8'h22);
        step(1, 0, 8'd3, 8'h00, 1, 0, 8'd4, 8'h00, 1, 0, 8'h33);
        step(1, 0, 8'd5, 8'h00, 1, 0, 8'd4, 8'h00, 0, 1, 8'h44);
`else
        step(1, 0, 8'd1, 8'h00, 1, 0, 8'd4, 8'h00, 1, 0, 8'h11);
        step(1, 0, 8'd2, 8'h00, 1, 0, 8'd4, 8'h00, 1, 0, 8'h22);
        step(1, 0, 8'd3, 8'h00, 1, 0, 8'd4, 8'h00, 1, 0, 8'h33);
        step(1, 0, 8'd4, 8'h00, 1, 0, 8'd4, 8'h00, 1, 0, 8'h44);
`endif
        idle(5);

        // Write then read of the same address on the next cycle.
        step(0, 0, 8'd0, 8'h00, 1, 1, 8'd7, 8'h3C, 0, 1, 8'h00);
        @(posedge clk);
        #1;
        chk("wr_bram_cmd", 32'({a_en, a_we, a_addr, a_di}), 32'({1'b1, 1'b1, 8'd7, 8'h3C}));
        step(1, 0, 8'd7, 8'h00, 0, 0, 8'd0, 8'h00, 1, 0, 8'h3C);
        idle(5);

        // Back-to-back reads from alternating ports, then the busy window.
        step(1, 0, 8'd5, 8'h00, 0, 0, 8'd0, 8'h00, 1, 0, 8'hA5);
        n0 = cyc;
        step(0, 0, 8'd0, 8'h00, 1, 0, 8'd1, 8'h00, 0, 1, 8'h11);
        step(1, 0, 8'd7, 8'h00, 0, 0, 8'd0, 8'h00, 1, 0, 8'h3C);
        for (int k = 3; k <= 6; k++) begin
            idle(1);
            #1;
            chk("A_busy", 32'(a_busy), 32'(cyc <= n0 + 4));
            chk("B_busy", 32'(b_busy), 32'(cyc <= n0 + 5));
        end
        idle(3);

        // Reset one cycle after a contended read is accepted; that read is dropped.
        @(negedge clk);
        r0v = 1'b1; r0we = 1'b0; r0a = 8'd5;
        r1v = 1'b1; r1we = 1'b0; r1a = 8'd1;
        #1;
        chk("pre_rst_ready", 32'({a_rdy0, a_rdy1}), 32'(2'b10));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'({a_en, b_en, a_busy, b_busy, a_rdy0, a_rdy1}), 32'(6'b000000));
        chk("mid_rst_addr", 32'({a_addr, b_addr}), 32'(16'h0000));
        idle(2);
        rst = 1'b0;
        idle(4);
        #1;
        chk("post_rst_state", 32'({a_en, b_en, a_busy, b_busy}), 32'(4'b0000));
        // prio cleared by reset: port 0 wins the first contended grant.
        step(1, 0, 8'd1, 8'h00, 1, 0, 8'd2, 8'h00, 1, 0, 8'h11);
        idle(6);

        chk("A_queue_drained", 32'(qa.size()), 32'd0);
        chk("B_queue_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram1_arbiter.md
# bram1_arbiter

Two-requester arbiter and sequencer for the single-ported load BRAM (boot/instruction memory). It shares the BRAM's one port between requester 0 (fetch) and requester 1 (load/store). It accepts at most one command per cycle, drives registered EN/WE/ADDR/DI into the BRAM, and returns read data to the issuing requester after the BRAM's fixed read latency. It sits between the core's memory-side request ports and the BRAM instance.

## Interface
- ADDR_WIDTH, 1: BRAM address width.
- DATA_WIDTH, 1: BRAM data width.
- PIPELINED, 0: must match the BRAM's PIPELINED setting. Read latency L = 1 + PIPELINED.

Ports (all 1 bit unless a width is given):
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- r0_req_valid / r1_req_valid  in  request valid.
- r0_req_ready / r1_req_ready  out  request accepted this cycle.
- r0_req_we / r1_req_we  in  1 = write, 0 = read.
- r0_req_addr / r1_req_addr  in  ADDR_WIDTH  word address.
- r0_req_wdata / r1_req_wdata  in  DATA_WIDTH  write data.
- r0_resp_valid / r1_resp_valid  out  read data valid, one-cycle pulse, no backpressure.
- r0_resp_data / r1_resp_data  out  DATA_WIDTH  read data.
- BRAM_EN, BRAM_WE  out  BRAM port enable and write enable.
- BRAM_ADDR  out  ADDR_WIDTH  BRAM address.
- BRAM_DI  out  DATA_WIDTH  BRAM write data.
- BRAM_DO  in  DATA_WIDTH  BRAM read data.
- busy  out  1 while any read is in flight.

## Operation
- Arbitration is combinational from the valids and the priority state. At most one rX_req_ready is high per cycle. ready is never high without the matching valid.
- Only one requester valid: it is granted.
- Both valid, with BRAM_ARB_ROUND_ROBIN_EN defined:
  - grant goes to the port not granted at the last contended grant.
  - prio register is 1 bit, reset 0, meaning port 0 wins first.
  - prio flips only on contended grants.
- Handshake: a command transfers when valid && ready. The requester holds valid, we, addr and wdata stable until ready. A requester may drop valid without penalty when it is not granted.
- Accepted command is registered into BRAM_EN=1, BRAM_WE, BRAM_ADDR, BRAM_DI for exactly one cycle. In idle cycles BRAM_EN=0, BRAM_WE=0; ADDR and DI hold their previous values.
- Accepted reads push {valid, port id} into an L+1-deep tracking shift register. At the tap, resp_valid is pulsed on the tagged port and rX_resp_data = BRAM_DO.
- Both resp_data outputs are wired directly to BRAM_DO. Only resp_valid is steered.
- Writes produce no response. The BRAM's DO is unchanged by a write, so read data is never corrupted.
- Ordering is strictly in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- busy = OR of all tracker valid bits.
- Reset, when asserted, clears the following:
  - all tracker entries, so in-flight reads are dropped and no resp_valid appears after reset;
  - prio = 0;
  - BRAM_EN = BRAM_WE = 0, BRAM_ADDR = 0, BRAM_DI = 0;
  - all resp_valid = 0, busy = 0.
- req_ready is 0 while RST is high.

## Timing
- Cycle N: valid && ready (acceptance).
- Cycle N+1: BRAM_EN high with the command. The BRAM samples at the end of N+1.
- Read response: rX_resp_valid in cycle N+1+L. That is N+2 for PIPELINED=0 and N+3 for PIPELINED=1.
- Throughput: one command per cycle sustained, with back-to-back reads from alternating ports.
- Zero-cycle combinational path from valid to ready. No combinational path from any req input to a BRAM_* output.

## Configuration
- BRAM_ARB_ROUND_ROBIN_EN defined: round-robin on contention, using the prio register.
- BRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins. The prio register is not built. Port 1 may starve; this is accepted for fetch-priority builds.

## Structure
- Shared package bram_arb_pkg holds:
  - port-id constants PORT_FETCH=0 and PORT_LSU=1;
  - the tracker entry struct {valid, port};
  - the latency function L(PIPELINED).
- One sub-module, bram_rsp_tracker: a parameterised-depth shift register of tracker entries with a tap output and an any-valid output.

## Test plan
- Single read: preload addr 5 = 0xA5, r0 reads 5 with PIPELINED=0 -> r0_resp_valid in cycle N+2, data 0xA5, r1_resp_valid stays 0.
- Contention with round-robin: both valid for 4 cycles, reading addrs 1..4 -> grants r0,r1,r0,r1, responses in the same order at latency L.
- Fixed priority (macro undefined): both valid for 4 cycles -> r0 granted all 4 cycles, r1_req_ready=0 throughout.
- Write then read: r1 writes 0x3C to addr 7, then r0 reads 7 the next cycle -> r0_resp_data = 0x3C. No response pulse is generated for the write.
- PIPELINED=1: 3 back-to-back reads -> responses in N+3, N+4, N+5, with busy high from N+1 through N+5.
- Reset mid-flight: assert RST one cycle after accepting a read -> no resp_valid afterwards, BRAM_EN=0, busy=0, prio=0.
